// File: rtl/bnorm_pkg.sv
// Shared widths, Q-format constants, parameter-table entry and FSM states for the bnorm sequencer.
package bnorm_pkg;
    localparam int DATA_W    = 16;
    localparam int PARAM_W   = 12;
    localparam int OUT_W     = 12;
    localparam int FRAC_BITS = 8;

    typedef struct packed {
        logic [PARAM_W-1:0] theta;
        logic [PARAM_W-1:0] phi;
    } bnorm_param_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT,
        ST_EMIT,
        ST_DONE
    } bnorm_ctrl_state_t;
endpackage

// File: rtl/bnorm_param_rf.sv
// Per-channel {theta, phi} table: one write port, combinational read, zero read latency.
// No reset and no backpressure; entries are undefined until written.
module bnorm_param_rf
    import bnorm_pkg::*;
#(
    parameter int NCH = 16,
    parameter int AW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [2*PARAM_W-1:0] wdat,
    input  logic [AW-1:0]        raddr,
    output logic [2*PARAM_W-1:0] rdat
);
    // Sized to the full address space so any address width indexes cleanly.
    bnorm_param_t mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdat;
        end
    end

    assign rdat = mem[raddr];
endmodule

// File: rtl/bnorm_ctrl.sv
// Sequences one bnorm op per Q8.8 sample with its channel's params; 4 cycles/sample minimum.
// Stalls in FETCH/WAIT/EMIT for in_valid/bn_finish/out_ready; BNORM_CTRL_TIMEOUT_EN bounds WAIT.
module bnorm_ctrl
    import bnorm_pkg::*;
#(
    parameter int NCH  = 16,
    parameter int NPIX = 64,
`ifdef BNORM_CTRL_TIMEOUT_EN
    parameter int TIMEOUT = 15,
`endif
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [CW-1:0]      cfg_addr,
    input  logic [PARAM_W-1:0] cfg_theta,
    input  logic [PARAM_W-1:0] cfg_phi,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               err,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               bn_ready,
    output logic [DATA_W-1:0]  bn_data,
    output logic [PARAM_W-1:0] bn_theta,
    output logic [PARAM_W-1:0] bn_phi,
    input  logic               bn_finish,
    input  logic [OUT_W-1:0]   bn_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic [CW-1:0]      out_ch,
    output logic               out_last_ch,
    output logic               out_last
);
    localparam int PW = (NPIX > 1) ? $clog2(NPIX) : 1;

    bnorm_ctrl_state_t state, state_nxt;
    logic [CW-1:0]     ch_cnt;
    logic [PW-1:0]     pix_cnt;
    logic [DATA_W-1:0] data_q;
    bnorm_param_t      rd_param;
    logic              idle, pix_last, ch_last, out_hs, tmo_hit;

    assign idle     = (state == ST_IDLE);
    assign pix_last = (pix_cnt == PW'(NPIX - 1));
    assign ch_last  = (ch_cnt == CW'(NCH - 1));
    assign out_hs   = (state == ST_EMIT) && out_ready;
    assign out_ch   = ch_cnt;

    bnorm_param_rf #(.NCH(NCH)) u_param_rf (
        .clk   (clk),
        .we    (cfg_we && idle),
        .waddr (cfg_addr),
        .wdat  ({cfg_theta, cfg_phi}),
        .raddr (ch_cnt),
        .rdat  (rd_param)
    );

`ifdef BNORM_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;
    logic          err_q;

    // A finish arriving on the last allowed cycle still wins over the timeout.
    assign tmo_hit = (state == ST_WAIT) && !bn_finish && (tmo_cnt == TW'(TIMEOUT - 1));
    assign err     = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            tmo_cnt <= (state == ST_WAIT) ? tmo_cnt + 1'b1 : '0;
            if (idle && start) begin
                err_q <= 1'b0;
            end else if (tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        busy        = !idle;
        done        = 1'b0;
        in_ready    = 1'b0;
        bn_ready    = 1'b0;
        bn_data     = '0;
        bn_theta    = '0;
        bn_phi      = '0;
        out_valid   = 1'b0;
        out_last_ch = 1'b0;
        out_last    = 1'b0;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_FETCH;
            ST_FETCH: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ST_ISSUE;
            end
            ST_ISSUE, ST_WAIT: begin
                bn_ready = (state == ST_ISSUE);
                bn_data  = data_q;
                bn_theta = rd_param.theta;
                bn_phi   = rd_param.phi;
                if (state == ST_ISSUE) begin
                    state_nxt = ST_WAIT;
                end else if (bn_finish || tmo_hit) begin
                    state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                out_valid   = 1'b1;
                out_last_ch = pix_last;
                out_last    = pix_last && ch_last;
                if (out_ready) state_nxt = (pix_last && ch_last) ? ST_DONE : ST_FETCH;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            ch_cnt   <= '0;
            pix_cnt  <= '0;
            data_q   <= '0;
            out_data <= '0;
        end else begin
            state <= state_nxt;
            if (idle && start) begin
                ch_cnt  <= '0;
                pix_cnt <= '0;
            end else if (out_hs) begin
                if (pix_last) begin
                    pix_cnt <= '0;
                    ch_cnt  <= ch_last ? '0 : ch_cnt + 1'b1;
                end else begin
                    pix_cnt <= pix_cnt + 1'b1;
                end
            end
            if ((state == ST_FETCH) && in_valid) begin
                data_q <= in_data;
            end
            if ((state == ST_WAIT) && bn_finish) begin
                out_data <= bn_out;
            end else if (tmo_hit) begin
                out_data <= '0;
            end
        end
    end
endmodule

// File: tb/tb_bnorm_ctrl.sv
// Directed bench: a 2x2 instance and a 1x1 instance, each driven by a behavioural bnorm model.
module tb_bnorm_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        hang = 1'b0;
    logic        start = 1'b0, cfg_we = 1'b0, cfg_addr = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [11:0] cfg_theta = '0, cfg_phi = '0;
    logic [15:0] in_data = '0;
    int          n_chk = 0, n_err = 0, a_done_n = 0, done_snap;

    logic        a_busy, a_done, a_err, a_in_ready, a_bn_ready, a_out_valid, a_out_last_ch, a_out_last;
    logic        a_out_ch, a_fin = 1'b0, a_prev = 1'b0;
    logic [15:0] a_bn_data;
    logic [11:0] a_bn_theta, a_bn_phi, a_out_data, a_bn_out = '0;
    logic        b_busy, b_done, b_err, b_in_ready, b_bn_ready, b_out_valid, b_out_last_ch, b_out_last;
    logic        b_out_ch, b_fin = 1'b0, b_prev = 1'b0;
    logic [15:0] b_bn_data;
    logic [11:0] b_bn_theta, b_bn_phi, b_out_data, b_bn_out = '0;

    logic [7:0]  a_ctl, b_ctl, c_ctl;
    logic [11:0] c_out_data;
    logic [15:0] c_bn_data;
    logic        c_out_ch;

    assign a_ctl = {a_busy, a_done, a_err, a_in_ready, a_bn_ready, a_out_valid, a_out_last_ch, a_out_last};
    assign b_ctl = {b_busy, b_done, b_err, b_in_ready, b_bn_ready, b_out_valid, b_out_last_ch, b_out_last};
    assign c_ctl      = sel ? b_ctl : a_ctl;
    assign c_out_data = sel ? b_out_data : a_out_data;
    assign c_bn_data  = sel ? b_bn_data : a_bn_data;
    assign c_out_ch   = sel ? b_out_ch : a_out_ch;

    always #5 clk = ~clk;

    bnorm_ctrl #(.NCH(2), .NPIX(2)) u_dut_a (
        .clk(clk), .rst(rst), .cfg_we(cfg_we & ~sel), .cfg_addr(cfg_addr),
        .cfg_theta(cfg_theta), .cfg_phi(cfg_phi), .start(start & ~sel),
        .busy(a_busy), .done(a_done), .err(a_err),
        .in_valid(in_valid & ~sel), .in_ready(a_in_ready), .in_data(in_data),
        .bn_ready(a_bn_ready), .bn_data(a_bn_data), .bn_theta(a_bn_theta), .bn_phi(a_bn_phi),
        .bn_finish(a_fin), .bn_out(a_bn_out),
        .out_valid(a_out_valid), .out_ready(out_ready & ~sel), .out_data(a_out_data),
        .out_ch(a_out_ch), .out_last_ch(a_out_last_ch), .out_last(a_out_last)
    );

    bnorm_ctrl #(.NCH(1), .NPIX(1)) u_dut_b (
        .clk(clk), .rst(rst), .cfg_we(cfg_we & sel), .cfg_addr(cfg_addr),
        .cfg_theta(cfg_theta), .cfg_phi(cfg_phi), .start(start & sel),
        .busy(b_busy), .done(b_done), .err(b_err),
        .in_valid(in_valid & sel), .in_ready(b_in_ready), .in_data(in_data),
        .bn_ready(b_bn_ready), .bn_data(b_bn_data), .bn_theta(b_bn_theta), .bn_phi(b_bn_phi),
        .bn_finish(b_fin), .bn_out(b_bn_out),
        .out_valid(b_out_valid), .out_ready(out_ready & sel), .out_data(b_out_data),
        .out_ch(b_out_ch), .out_last_ch(b_out_last_ch), .out_last(b_out_last)
    );

    // relu(theta * x + phi): Q8.8 * Q4.8 -> Q.16, back to Q.8, clipped to 12 bits unsigned.
    function automatic logic [11:0] bn_model(input logic [15:0] x, input logic [11:0] th,
                                             input logic [11:0] ph);
        logic signed [27:0] p;
        logic signed [28:0] s;
        p = 28'($signed(x)) * 28'($signed(th));
        s = 29'(p >>> 8) + 29'($signed(ph));
        if (s < 0) return 12'h000;
        if (s > 29'sd4095) return 12'hFFF;
        return s[11:0];
    endfunction

    // bn_finish asserted in the cycle after bn_ready, unless hang is set.
    always @(negedge clk) begin
        a_fin = a_prev & ~hang;
        if (a_prev) a_bn_out = bn_model(a_bn_data, a_bn_theta, a_bn_phi);
        a_prev = a_bn_ready;
        b_fin = b_prev & ~hang;
        if (b_prev) b_bn_out = bn_model(b_bn_data, b_bn_theta, b_bn_phi);
        b_prev = b_bn_ready;
    end

    always @(posedge clk) if (a_done) a_done_n++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", c_ctl[7], 1);
    endtask

    task automatic cfg_write(input logic a, input logic [11:0] th, input logic [11:0] ph);
        cfg_we = 1'b1; cfg_addr = a; cfg_theta = th; cfg_phi = ph;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic run_sample(input string tag, input logic [15:0] x, input logic [11:0] exp_d,
                              input logic exp_ch, input logic exp_lc, input logic exp_l,
                              input int stall, input int lat);
        int k;
        in_data = x; in_valid = 1'b1;
        k = 0;
        while (!c_ctl[4] && k < 50) begin @(negedge clk); k++; end
        check({tag, "/in_ready"}, c_ctl[4], 1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "/bn_ready"}, c_ctl[3], 1);
        check({tag, "/bn_data"}, c_bn_data, x);
        k = 1;
        while (!c_ctl[2] && k < 50) begin @(negedge clk); k++; end
        check({tag, "/latency"}, k, lat);
        check({tag, "/out_data"}, c_out_data, exp_d);
        check({tag, "/flags"}, {c_out_ch, c_ctl[1], c_ctl[0]}, {exp_ch, exp_lc, exp_l});
        repeat (stall) begin
            @(negedge clk);
            check({tag, "/hold"}, {c_ctl[2], c_out_data}, {1'b1, exp_d});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "/done"}, c_ctl[6], exp_l);
    endtask

    task automatic pass_a(input string tag, input logic zero, input int lat);
        for (int i = 0; i < 4; i++) begin
            if (i == 2 && !zero) begin
                // Mid-pass start and table write must both be ignored.
                cfg_we = 1'b1; cfg_addr = 1'b1; cfg_theta = 12'h300; start = 1'b1;
                @(negedge clk);
                cfg_we = 1'b0; start = 1'b0;
            end
            run_sample(tag, 16'h0100, zero ? 12'h000 : ((i < 2) ? 12'h200 : 12'h180),
                       i[1], i[0], (i == 3), 0, lat);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst/a_ctl", a_ctl, 0);
        check("rst/b_ctl", b_ctl, 0);
        check("rst/out_data", {a_out_data, b_out_data}, 0);
        check("rst/bn_ops", {a_bn_data, a_bn_theta, a_bn_phi, a_out_ch, b_out_ch}, 0);
        rst = 1'b1;
        @(negedge clk);

        sel = 1'b1;
        cfg_write(1'b0, 12'h100, 12'h000);
        do_start();
        run_sample("t1", 16'h0100, 12'h100, 1'b0, 1'b1, 1'b1, 0, 3);
        check("t1/busy_in_done", c_ctl[7], 1);
        @(negedge clk);
        check("t1/idle_after", {c_ctl[7], c_ctl[6]}, 0);

        do_start();
        run_sample("relu", 16'hFF00, 12'h000, 1'b0, 1'b1, 1'b1, 5, 3);
        @(negedge clk);

        cfg_we = 1'b1; cfg_addr = 1'b0; cfg_theta = 12'h180; cfg_phi = 12'h000; start = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0; start = 1'b0;
        run_sample("wr_start", 16'h0100, 12'h180, 1'b0, 1'b1, 1'b1, 0, 3);
        @(negedge clk);

        sel = 1'b0;
        cfg_write(1'b0, 12'h200, 12'h000);
        cfg_write(1'b1, 12'h100, 12'h080);
        do_start();
        pass_a("t2", 1'b0, 3);
        @(negedge clk);
        check("t2/idle_after", c_ctl[7], 0);

        do_start();
        pass_a("t2b", 1'b0, 3);
        @(negedge clk);

        done_snap = a_done_n;
        do_start();
        hang = 1'b1;
        in_data = 16'h0100; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("rwait/bn_ready", a_bn_ready, 1);
        repeat (2) @(negedge clk);
        check("rwait/bn_theta", a_bn_theta, 12'h200);
        rst = 1'b0;
        #1;
        check("rwait/ctl", a_ctl, 0);
        check("rwait/data", {a_out_data, a_bn_data, a_bn_theta, a_bn_phi}, 0);
        @(negedge clk);
        rst = 1'b1; hang = 1'b0;
        repeat (2) @(negedge clk);
        check("rwait/idle", a_ctl, 0);
        check("rwait/no_done", a_done_n, done_snap);

`ifdef BNORM_CTRL_TIMEOUT_EN
        hang = 1'b1;
        do_start();
        pass_a("tmo", 1'b1, 17);
        check("tmo/err_set", a_err, 1);
        hang = 1'b0;
        @(negedge clk);
        do_start();
        check("tmo/err_clr", a_err, 0);
        pass_a("tmo_after", 1'b0, 3);
`else
        check("err_tied", a_err, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
